bz_pll_reset_sequencer: RTL and testbench
=========================================

// Module: bz_pll_reset_sequencer
// PURPOSE
//  Consumer end of the host-core PLL interface. Runs on the free-running 100 MHz reference clock.
//  Drives the PLL's active-high reset and watches its lock output. Releases the core reset only
//  after lock has been continuously stable.
//  Re-resets the PLL on lock timeout, on loss of lock, or on software request. Counts failures.
//  Per-domain synchronization of sys_rst_n into the 150 MHz outclk domains is done downstream.
// PARAMETERS
//  PLL_RST_CYCLES  16      clk cycles pll_rst is held high per reset attempt (>=2)
//  LOCK_TIMEOUT    100000  clk cycles to wait for lock before retrying (1 ms)
//  STABLE_CYCLES   1024    clk cycles lock must hold continuously before core reset release
//  CNT_W           8       width of saturating event counters
// PORTS
//  clk          in   1      reference clock, same net as PLL refclk
//  rst_n        in   1      async active-low reset
//  pll_locked   in   1      PLL locked; asynchronous, 2-FF synchronized internally (locked_s)
//  sw_rst_req   in   1      1-cycle pulse: force PLL re-reset
//  clr_counts   in   1      1-cycle pulse: zero timeout_cnt and loss_cnt
//  pll_rst      out  1      to PLL rst, active high
//  sys_rst_n    out  1      core reset, active low; 1 only in RUN
//  state        out  2      0=PLL_RESET 1=WAIT_LOCK 2=STABLE 3=RUN
//  timeout_cnt  out  CNT_W  lock timeouts since clear, saturating
//  loss_cnt     out  CNT_W  losses of lock in RUN since clear, saturating
// BEHAVIOUR
//  Reset values (async, rst_n=0):
//   - state=PLL_RESET, pll_rst=1, sys_rst_n=0.
//   - timer, sync FFs, timeout_cnt and loss_cnt all 0.
//  Registered outputs: pll_rst=(state==PLL_RESET) and sys_rst_n=(state==RUN). Both change on the
//   same edge as state. No combinational path from inputs to outputs.
//  Timer: width $clog2 of max parameter. Cleared on every state change. Else increments by 1.
//  PLL_RESET:
//   - At timer==PLL_RST_CYCLES-1 -> WAIT_LOCK.
//   - pll_rst is high for exactly PLL_RST_CYCLES edges after reset release.
//  WAIT_LOCK:
//   - locked_s=1 -> STABLE.
//   - Else at timer==LOCK_TIMEOUT-1 -> PLL_RESET and timeout_cnt+1.
//  STABLE:
//   - locked_s=0 -> WAIT_LOCK. This is a glitch: no count, timer restarts.
//   - Else at timer==STABLE_CYCLES-1 -> RUN.
//  RUN:
//   - Stays while locked_s=1.
//   - locked_s=0 -> PLL_RESET and loss_cnt+1. sys_rst_n falls on that edge.
//  Priority, per edge: rst_n > sw_rst_req > state transitions.
//   - sw_rst_req in any state -> PLL_RESET, timer=0, no counter change.
//   - This includes PLL_RESET, where it restarts the hold.
//  Counters saturate at 2^CNT_W-1 with no wrap. clr_counts on the same edge as an increment -> 0.
//  Lock latency: a pll_locked change is seen by the FSM 2 edges later. It acts on the 3rd edge.
//  rst_n asserted mid-operation:
//   - Immediately pll_rst=1 and sys_rst_n=0.
//   - The full sequence restarts on release.
// TESTING  (PLL_RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=8, CNT_W=4; edges counted from rst_n release)
//  1. pll_locked=1 throughout.
//     -> pll_rst falls after edge 4; STABLE after edge 5; sys_rst_n rises after edge 13; state=3.
//  2. pll_locked=0 throughout.
//     -> pll_rst re-pulses every 54 cycles; timeout_cnt 1,2,... saturates at 15; sys_rst_n stays 0.
//  3. In RUN, pll_locked low 1 cycle.
//     -> sys_rst_n falls 3 edges later; loss_cnt=1; full 4+1+8 sequence reruns to RUN.
//  4. pll_locked low 1 cycle while STABLE with timer=5.
//     -> WAIT_LOCK, counts unchanged; RUN 9 edges after locked_s re-asserts.
//  5. sw_rst_req on same edge as lock-loss in RUN, clr_counts on a saturating increment.
//     -> PLL_RESET with loss_cnt unchanged; counts read 0.
//  6. rst_n pulsed low mid-STABLE.
//     -> pll_rst=1 and sys_rst_n=0 before the next edge; all counters 0; scenario 1 timing repeats.

Source files
------------

// File: rtl/bz_pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable lock, then releases
// the core reset. Retries on timeout, lock loss or software request and counts failures.
module bz_pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 100000,
   parameter int STABLE_CYCLES  = 1024,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pll_locked,
   input  logic             sw_rst_req,
   input  logic             clr_counts,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] timeout_cnt,
   output logic [CNT_W-1:0] loss_cnt
);

   localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
   localparam int TMR_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic               sync1_q, sync1_d;
   logic               locked_s_q, locked_s_d;
   logic [CNT_W-1:0]   timeout_cnt_q, timeout_cnt_d;
   logic [CNT_W-1:0]   loss_cnt_q, loss_cnt_d;
   logic               pll_rst_q, pll_rst_d;
   logic               sys_rst_n_q, sys_rst_n_d;
   logic               timeout_inc, loss_inc;

   always_comb begin
      state_d     = state_q;
      timeout_inc = 1'b0;
      loss_inc    = 1'b0;
      sync1_d     = pll_locked;
      locked_s_d  = sync1_q;

      if (sw_rst_req) begin
         state_d = PLL_RESET;
      end else begin
         unique case (state_q)
            PLL_RESET: begin
               if (timer_q == TMR_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (locked_s_q) begin
                  state_d = STABLE;
               end else if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  state_d     = PLL_RESET;
                  timeout_inc = 1'b1;
               end
            end
            STABLE: begin
               if (!locked_s_q) begin
                  state_d = WAIT_LOCK;
               end else if (timer_q == TMR_W'(STABLE_CYCLES - 1)) begin
                  state_d = RUN;
               end
            end
            RUN: begin
               if (!locked_s_q) begin
                  state_d  = PLL_RESET;
                  loss_inc = 1'b1;
               end
            end
            default: state_d = PLL_RESET;
         endcase
      end

      // A software request in PLL_RESET keeps the state but must still restart the hold
      if (sw_rst_req || (state_d != state_q)) timer_d = '0;
      else                                     timer_d = timer_q + TMR_W'(1);

      if (clr_counts)                             timeout_cnt_d = '0;
      else if (timeout_inc && timeout_cnt_q != '1) timeout_cnt_d = timeout_cnt_q + CNT_W'(1);
      else                                        timeout_cnt_d = timeout_cnt_q;

      if (clr_counts)                       loss_cnt_d = '0;
      else if (loss_inc && loss_cnt_q != '1) loss_cnt_d = loss_cnt_q + CNT_W'(1);
      else                                  loss_cnt_d = loss_cnt_q;

      pll_rst_d   = (state_d == PLL_RESET);
      sys_rst_n_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= PLL_RESET;
         timer_q       <= '0;
         sync1_q       <= 1'b0;
         locked_s_q    <= 1'b0;
         timeout_cnt_q <= '0;
         loss_cnt_q    <= '0;
         pll_rst_q     <= 1'b1;
         sys_rst_n_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         sync1_q       <= sync1_d;
         locked_s_q    <= locked_s_d;
         timeout_cnt_q <= timeout_cnt_d;
         loss_cnt_q    <= loss_cnt_d;
         pll_rst_q     <= pll_rst_d;
         sys_rst_n_q   <= sys_rst_n_d;
      end
   end

   assign pll_rst     = pll_rst_q;
   assign sys_rst_n   = sys_rst_n_q;
   assign state       = state_q;
   assign timeout_cnt = timeout_cnt_q;
   assign loss_cnt    = loss_cnt_q;

endmodule

// File: tb/tb_bz_pll_reset_sequencer.sv
// Bench for bz_pll_reset_sequencer: fixed vector table, hand-written corner sequences and
// a randomized run checked against a phase/elapsed-time reference model.
module tb_bz_pll_reset_sequencer;

   localparam int PRC  = 4;
   localparam int LTO  = 50;
   localparam int STC  = 8;
   localparam int CW   = 4;
   localparam int SATV = (1 << CW) - 1;

   logic          clk;
   logic          rst_n;
   logic          pll_locked;
   logic          sw_rst_req;
   logic          clr_counts;
   logic          pll_rst;
   logic          sys_rst_n;
   logic [1:0]    state;
   logic [CW-1:0] timeout_cnt;
   logic [CW-1:0] loss_cnt;

   bz_pll_reset_sequencer #(
      .PLL_RST_CYCLES(PRC),
      .LOCK_TIMEOUT  (LTO),
      .STABLE_CYCLES (STC),
      .CNT_W         (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .sw_rst_req (sw_rst_req),
      .clr_counts (clr_counts),
      .pll_rst    (pll_rst),
      .sys_rst_n  (sys_rst_n),
      .state      (state),
      .timeout_cnt(timeout_cnt),
      .loss_cnt   (loss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int edges;
      bit lk;
      bit sw;
      bit clr;
      int expState;
      bit expPllRst;
      bit expSysRstN;
      int expTo;
      int expLoss;
   } vec_t;

   vec_t tbl[16];

   int vectors = 0;
   int miscompares = 0;

   // Reference model: phase number, cycles spent in it, and the lock value as the FSM sees it
   int mPhase, mElapsed, mTo, mLoss;
   bit lockPipe[$];
   int phaseLen[4];

   int holdLeft;
   bit rndLk;

   task automatic checkOutput(input string name, input int got, input int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mPhase   = 0;
      mElapsed = 0;
      mTo      = 0;
      mLoss    = 0;
      lockPipe = {1'b0, 1'b0};
   endfunction

   function automatic void modelStep(input bit lk, input bit sw, input bit clr);
      bit seen;
      bit expired;
      int nxt;
      bit toEv;
      bit lossEv;
      seen    = lockPipe[0];
      expired = (mElapsed + 1 >= phaseLen[mPhase]);
      nxt     = mPhase;
      toEv    = 1'b0;
      lossEv  = 1'b0;
      void'(lockPipe.pop_front());
      lockPipe.push_back(lk);
      if (sw) nxt = 0;
      else if (mPhase == 0 && expired) nxt = 1;
      else if (mPhase == 1 && seen) nxt = 2;
      else if (mPhase == 1 && expired) begin nxt = 0; toEv = 1'b1; end
      else if (mPhase == 2 && !seen) nxt = 1;
      else if (mPhase == 2 && expired) nxt = 3;
      else if (mPhase == 3 && !seen) begin nxt = 0; lossEv = 1'b1; end
      mElapsed = (sw || nxt != mPhase) ? 0 : mElapsed + 1;
      mPhase   = nxt;
      if (clr) begin
         mTo   = 0;
         mLoss = 0;
      end else begin
         if (toEv)   mTo   = (mTo   + 1 > SATV) ? SATV : mTo + 1;
         if (lossEv) mLoss = (mLoss + 1 > SATV) ? SATV : mLoss + 1;
      end
   endfunction

   task automatic applyStimulus(input int edges);
      repeat (edges) begin
         @(posedge clk);
         modelStep(pll_locked, sw_rst_req, clr_counts);
         #1;
      end
   endtask

   task automatic checkModel();
      checkOutput("model_state",     int'(state),       mPhase);
      checkOutput("model_pll_rst",   int'(pll_rst),     int'(mPhase == 0));
      checkOutput("model_sys_rst_n", int'(sys_rst_n),   int'(mPhase == 3));
      checkOutput("model_timeout",   int'(timeout_cnt), mTo);
      checkOutput("model_loss",      int'(loss_cnt),    mLoss);
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_state",     int'(state),       0);
      checkOutput("rst_pll_rst",   int'(pll_rst),     1);
      checkOutput("rst_sys_rst_n", int'(sys_rst_n),   0);
      checkOutput("rst_timeout",   int'(timeout_cnt), 0);
      checkOutput("rst_loss",      int'(loss_cnt),    0);
      modelReset();
      sw_rst_req = 1'b0;
      clr_counts = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic runTable(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         pll_locked = tbl[i].lk;
         sw_rst_req = tbl[i].sw;
         clr_counts = tbl[i].clr;
         applyStimulus(tbl[i].edges);
         checkOutput($sformatf("row%0d_state", i),     int'(state),       tbl[i].expState);
         checkOutput($sformatf("row%0d_pll_rst", i),   int'(pll_rst),     int'(tbl[i].expPllRst));
         checkOutput($sformatf("row%0d_sys_rst_n", i), int'(sys_rst_n),   int'(tbl[i].expSysRstN));
         checkOutput($sformatf("row%0d_timeout", i),   int'(timeout_cnt), tbl[i].expTo);
         checkOutput($sformatf("row%0d_loss", i),      int'(loss_cnt),    tbl[i].expLoss);
      end
      sw_rst_req = 1'b0;
      clr_counts = 1'b0;
   endtask

   initial begin
      phaseLen[0] = PRC;
      phaseLen[1] = LTO;
      phaseLen[2] = STC;
      phaseLen[3] = 1 << 30;

      // Lock held from release: 4 edges of PLL reset, STABLE after 5, RUN after 13
      tbl[0]  = '{3, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 0};
      tbl[1]  = '{1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0, 0};
      tbl[2]  = '{1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 0};
      tbl[3]  = '{7, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 0};
      tbl[4]  = '{1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1, 0, 0};
      tbl[5]  = '{5, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1, 0, 0};
      // One-cycle lock drop in RUN: acted on three edges later, then the full sequence reruns
      tbl[6]  = '{1, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1, 0, 0};
      tbl[7]  = '{1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1, 0, 0};
      tbl[8]  = '{1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1};
      tbl[9]  = '{3, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 0, 1};
      tbl[10] = '{1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 0, 1};
      tbl[11] = '{1, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1};
      tbl[12] = '{7, 1'b1, 1'b0, 1'b0, 2, 1'b0, 1'b0, 0, 1};
      tbl[13] = '{1, 1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b1, 0, 1};
      tbl[14] = '{1, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1};
      tbl[15] = '{1, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, 0, 0};

      rst_n      = 1'b1;
      pll_locked = 1'b1;
      sw_rst_req = 1'b0;
      clr_counts = 1'b0;
      #2;

      doReset();
      runTable(0, 15);

      $display("[TB] lock never arrives: timeout retries and saturation");
      pll_locked = 1'b0;
      doReset();
      for (int k = 1; k <= 17; k++) begin
         applyStimulus(PRC + LTO - 1);
         checkOutput($sformatf("to%0d_wait_state", k), int'(state), 1);
         clr_counts = (k == 17);
         applyStimulus(1);
         clr_counts = 1'b0;
         checkOutput($sformatf("to%0d_state", k),   int'(state),       0);
         checkOutput($sformatf("to%0d_pll_rst", k), int'(pll_rst),     1);
         checkOutput($sformatf("to%0d_sysrst", k),  int'(sys_rst_n),   0);
         checkOutput($sformatf("to%0d_count", k),   int'(timeout_cnt), (k == 17) ? 0 : ((k > SATV) ? SATV : k));
      end

      $display("[TB] glitch during STABLE");
      pll_locked = 1'b1;
      doReset();
      applyStimulus(8);
      pll_locked = 1'b0;
      applyStimulus(1);
      pll_locked = 1'b1;
      applyStimulus(1);
      checkOutput("glitch_pre_state", int'(state), 2);
      applyStimulus(1);
      checkOutput("glitch_state",   int'(state),       1);
      checkOutput("glitch_timeout", int'(timeout_cnt), 0);
      checkOutput("glitch_loss",    int'(loss_cnt),    0);
      applyStimulus(8);
      checkOutput("glitch_stable", int'(state), 2);
      applyStimulus(1);
      checkOutput("glitch_run",    int'(state),     3);
      checkOutput("glitch_sysrst", int'(sys_rst_n), 1);

      $display("[TB] software request on the lock-loss edge");
      doReset();
      applyStimulus(13);
      checkOutput("swloss_run", int'(state), 3);
      pll_locked = 1'b0;
      applyStimulus(2);
      checkOutput("swloss_pre", int'(state), 3);
      sw_rst_req = 1'b1;
      applyStimulus(1);
      sw_rst_req = 1'b0;
      pll_locked = 1'b1;
      checkOutput("swloss_state", int'(state),    0);
      checkOutput("swloss_loss",  int'(loss_cnt), 0);

      $display("[TB] async reset in STABLE");
      doReset();
      applyStimulus(13);
      pll_locked = 1'b0;
      applyStimulus(1);
      pll_locked = 1'b1;
      applyStimulus(2);
      checkOutput("ar_loss", int'(loss_cnt), 1);
      applyStimulus(5);
      checkOutput("ar_stable", int'(state), 2);
      applyStimulus(2);
      #3;
      doReset();
      runTable(0, 5);

      $display("[TB] randomized run against reference model");
      doReset();
      holdLeft = 0;
      for (int c = 0; c < 3000; c++) begin
         if (holdLeft == 0) begin
            rndLk    = 1'($urandom_range(0, 1));
            holdLeft = rndLk ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 70));
         end
         holdLeft--;
         pll_locked = rndLk;
         sw_rst_req = ($urandom_range(0, 149) == 0);
         clr_counts = ($urandom_range(0, 99) == 0);
         applyStimulus(1);
         checkModel();
      end
      sw_rst_req = 1'b0;
      clr_counts = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
